sad_sequencer: RTL and testbench

Controller for the SAD (sum-of-absolute-differences) block-matching datapath behind the Memory→SAD1 pipeline register. It decodes the 2-bit SAD opcode leaving the Memory stage, tracks whether a reference window has been loaded, and launches one SAD computation per candidate frame position. It stalls the upstream pipeline while the datapath is busy, tracks the running minimum SAD with its candidate address, and flags protocol and timeout errors.

---
 rtl/sad_sequencer_if.sv | 33 +++
 rtl/sad_sequencer.sv | 102 ++++++++++
 tb/tb_sad_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sad_sequencer_if.sv
// Memory-stage SAD opcode/result bus between the pipeline/datapath (master) and the SAD sequencer (slave).
interface sad_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [1:0]        SADM;
  logic [ADDR_W-1:0] FrameAddrM;
  logic              SadDone;
  logic [31:0]       SadResult;
  logic              ErrClear;
  logic              SadStart;
  logic              StallSAD;
  logic              Busy;
  logic              WinValid;
  logic [31:0]       BestSAD;
  logic [ADDR_W-1:0] BestAddr;
  logic              BestValid;
  logic [CNT_W-1:0]  CandCount;
  logic              ErrNoWin;
  logic              ErrTimeout;

  modport master (
    output SADM, FrameAddrM, SadDone, SadResult, ErrClear,
    input  SadStart, StallSAD, Busy, WinValid, BestSAD, BestAddr,
           BestValid, CandCount, ErrNoWin, ErrTimeout
  );

  modport slave (
    input  SADM, FrameAddrM, SadDone, SadResult, ErrClear,
    output SadStart, StallSAD, Busy, WinValid, BestSAD, BestAddr,
           BestValid, CandCount, ErrNoWin, ErrTimeout
  );
endinterface

// File: rtl/sad_sequencer.sv
// SAD block-matching controller: launches one datapath run per accepted frame opcode, tracks the minimum SAD.
// SadStart one cycle after accept; StallSAD holds upstream while COMPUTE sees any opcode; next accept the edge after done.
module sad_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic            Clk,
  input logic            Reset,
  sad_sequencer_if.slave sad
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t            state;
  logic              sad_start;
  logic              win_valid;
  logic [31:0]       best_sad;
  logic [ADDR_W-1:0] best_addr;
  logic [ADDR_W-1:0] pend_addr;
  logic              best_valid;
  logic [CNT_W-1:0]  cand_count;
  logic [TW-1:0]     tcnt;
  logic              err_nowin;
  logic              err_timeout;

  logic frame_op;
  logic nowin_set;
  logic timeout_set;

  assign frame_op    = (sad.SADM == 2'd1) || (sad.SADM == 2'd2);
  assign nowin_set   = (state == IDLE) && frame_op && !win_valid;
  assign timeout_set = (state == COMPUTE) && !sad.SadDone && (tcnt == TO_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      sad_start   <= 1'b0;
      win_valid   <= 1'b0;
      best_sad    <= '1;
      best_addr   <= '0;
      pend_addr   <= '0;
      best_valid  <= 1'b0;
      cand_count  <= '0;
      tcnt        <= '0;
      err_nowin   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sad_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sad.SADM == 2'd3)
            win_valid <= 1'b1;
          if (frame_op && win_valid) begin
            pend_addr <= sad.FrameAddrM;
            sad_start <= 1'b1;
            tcnt      <= '0;
            state     <= COMPUTE;
            if (sad.SADM == 2'd1) begin
              best_sad   <= '1;
              best_valid <= 1'b0;
              cand_count <= '0;
            end
          end
        end
        COMPUTE: begin
          // Done beats a same-cycle timeout; strict compare keeps the earlier candidate on ties.
          if (sad.SadDone) begin
            if (sad.SadResult < best_sad) begin
              best_sad  <= sad.SadResult;
              best_addr <= pend_addr;
            end
            best_valid <= 1'b1;
            if (cand_count != '1)
              cand_count <= cand_count + CNT_W'(1);
            state <= IDLE;
          end else if (tcnt == TO_LAST) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      err_nowin   <= nowin_set   | (err_nowin   & ~sad.ErrClear);
      err_timeout <= timeout_set | (err_timeout & ~sad.ErrClear);
    end
  end

  assign sad.SadStart   = sad_start;
  assign sad.StallSAD   = (sad.SADM != 2'd0) && (state == COMPUTE);
  assign sad.Busy       = (state == COMPUTE);
  assign sad.WinValid   = win_valid;
  assign sad.BestSAD    = best_sad;
  assign sad.BestAddr   = best_addr;
  assign sad.BestValid  = best_valid;
  assign sad.CandCount  = cand_count;
  assign sad.ErrNoWin   = err_nowin;
  assign sad.ErrTimeout = err_timeout;
endmodule

// File: tb/tb_sad_sequencer.sv
// Directed, table-driven bench for sad_sequencer with hand sequences for timeout, reset and error corners.
module tb_sad_sequencer;
  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  sad_sequencer_if #(.ADDR_W(32), .CNT_W(16)) sif ();

  sad_sequencer #(.ADDR_W(32), .CNT_W(16), .TIMEOUT(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sad   (sif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  sadm;
    logic [31:0] addr;
    logic        done;
    logic [31:0] res;
    logic        stall;
    logic        start;
    logic        busy;
    logic [31:0] best;
    logic [31:0] baddr;
    logic        bval;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic [1:0] sadm, logic [31:0] addr, logic done, logic [31:0] res,
                              logic stall, logic start, logic busy, logic [31:0] best,
                              logic [31:0] baddr, logic bval, logic [15:0] cnt);
    vec_t v;
    v.sadm = sadm; v.addr = addr; v.done = done; v.res = res; v.stall = stall;
    v.start = start; v.busy = busy; v.best = best; v.baddr = baddr; v.bval = bval; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sadm, input logic [31:0] addr, input logic done,
                       input logic [31:0] res, input logic clr);
    sif.SADM = sadm; sif.FrameAddrM = addr; sif.SadDone = done; sif.SadResult = res; sif.ErrClear = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " start"}, 64'(sif.SadStart), 64'd0);
    chk({tag, " busy"},  64'(sif.Busy), 64'd0);
    chk({tag, " win"},   64'(sif.WinValid), 64'd0);
    chk({tag, " best"},  64'(sif.BestSAD), 64'hFFFF_FFFF);
    chk({tag, " baddr"}, 64'(sif.BestAddr), 64'd0);
    chk({tag, " bval"},  64'(sif.BestValid), 64'd0);
    chk({tag, " cnt"},   64'(sif.CandCount), 64'd0);
    chk({tag, " enowin"}, 64'(sif.ErrNoWin), 64'd0);
    chk({tag, " eto"},   64'(sif.ErrTimeout), 64'd0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;

    //              sadm addr       done res      stall st busy best           baddr      bv cnt
    tbl[0]  = mk(2'd3, 32'h0,     0, 32'h0,   0, 0, 0, 32'hFFFF_FFFF, 32'h0,   0, 16'd0);
    tbl[1]  = mk(2'd1, 32'h100,   0, 32'h0,   0, 1, 1, 32'hFFFF_FFFF, 32'h0,   0, 16'd0);
    tbl[2]  = mk(2'd0, 32'h0,     0, 32'h0,   0, 0, 1, 32'hFFFF_FFFF, 32'h0,   0, 16'd0);
    tbl[3]  = mk(2'd0, 32'h0,     1, 32'h50,  0, 0, 0, 32'h50,        32'h100, 1, 16'd1);
    tbl[4]  = mk(2'd2, 32'h104,   0, 32'h0,   0, 1, 1, 32'h50,        32'h100, 1, 16'd1);
    tbl[5]  = mk(2'd0, 32'h0,     1, 32'h40,  0, 0, 0, 32'h40,        32'h104, 1, 16'd2);
    tbl[6]  = mk(2'd2, 32'h108,   0, 32'h0,   0, 1, 1, 32'h40,        32'h104, 1, 16'd2);
    tbl[7]  = mk(2'd0, 32'h0,     1, 32'h40,  0, 0, 0, 32'h40,        32'h104, 1, 16'd3);
    tbl[8]  = mk(2'd2, 32'h10C,   0, 32'h0,   0, 1, 1, 32'h40,        32'h104, 1, 16'd3);
    tbl[9]  = mk(2'd0, 32'h0,     0, 32'h0,   0, 0, 1, 32'h40,        32'h104, 1, 16'd3);
    tbl[10] = mk(2'd0, 32'h0,     1, 32'h60,  0, 0, 0, 32'h40,        32'h104, 1, 16'd4);
    tbl[11] = mk(2'd2, 32'h200,   0, 32'h0,   0, 1, 1, 32'h40,        32'h104, 1, 16'd4);
    tbl[12] = mk(2'd2, 32'h204,   0, 32'h0,   1, 0, 1, 32'h40,        32'h104, 1, 16'd4);
    tbl[13] = mk(2'd2, 32'h204,   1, 32'h30,  1, 0, 0, 32'h30,        32'h200, 1, 16'd5);
    tbl[14] = mk(2'd2, 32'h204,   0, 32'h0,   0, 1, 1, 32'h30,        32'h200, 1, 16'd5);
    tbl[15] = mk(2'd3, 32'h0,     1, 32'h10,  1, 0, 0, 32'h10,        32'h204, 1, 16'd6);
    tbl[16] = mk(2'd0, 32'h0,     1, 32'h0,   0, 0, 0, 32'h10,        32'h204, 1, 16'd6);
    tbl[17] = mk(2'd1, 32'h300,   0, 32'h0,   0, 1, 1, 32'hFFFF_FFFF, 32'h204, 0, 16'd0);
    tbl[18] = mk(2'd0, 32'h0,     1, 32'h70,  0, 0, 0, 32'h70,        32'h300, 1, 16'd1);

    Reset = 1'b1;
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_vals("rst");
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].sadm, tbl[i].addr, tbl[i].done, tbl[i].res, 1'b0);
      #1;
      chk($sformatf("r%0d stall", i), 64'(sif.StallSAD), 64'(tbl[i].stall));
      tick();
      chk($sformatf("r%0d start", i), 64'(sif.SadStart), 64'(tbl[i].start));
      chk($sformatf("r%0d busy", i),  64'(sif.Busy), 64'(tbl[i].busy));
      chk($sformatf("r%0d win", i),   64'(sif.WinValid), 64'd1);
      chk($sformatf("r%0d best", i),  64'(sif.BestSAD), 64'(tbl[i].best));
      chk($sformatf("r%0d baddr", i), 64'(sif.BestAddr), 64'(tbl[i].baddr));
      chk($sformatf("r%0d bval", i),  64'(sif.BestValid), 64'(tbl[i].bval));
      chk($sformatf("r%0d cnt", i),   64'(sif.CandCount), 64'(tbl[i].cnt));
      chk($sformatf("r%0d errs", i),  64'({sif.ErrNoWin, sif.ErrTimeout}), 64'd0);
    end

    // Timeout: TIMEOUT=8 aborts after 7 COMPUTE cycles
    drive(2'd2, 32'h400, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (sif.Busy && n < 20) begin
      tick();
      n++;
    end
    chk("to cycles", 64'(n), 64'd7);
    chk("to err", 64'(sif.ErrTimeout), 64'd1);
    chk("to best", 64'(sif.BestSAD), 64'h70);
    chk("to cnt", 64'(sif.CandCount), 64'd1);
    drive(2'd0, 32'h0, 1'b1, 32'h1, 1'b0);
    tick();
    chk("late best", 64'(sif.BestSAD), 64'h70);
    chk("late cnt", 64'(sif.CandCount), 64'd1);
    chk("late busy", 64'(sif.Busy), 64'd0);
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("to clr", 64'(sif.ErrTimeout), 64'd0);

    // Done on the timeout-limit cycle wins
    drive(2'd2, 32'h500, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (6) tick();
    chk("tie busy", 64'(sif.Busy), 64'd1);
    drive(2'd0, 32'h0, 1'b1, 32'h5, 1'b0);
    tick();
    chk("tie err", 64'(sif.ErrTimeout), 64'd0);
    chk("tie best", 64'(sif.BestSAD), 64'h5);
    chk("tie baddr", 64'(sif.BestAddr), 64'h500);
    chk("tie cnt", 64'(sif.CandCount), 64'd2);
    chk("tie busy2", 64'(sif.Busy), 64'd0);

    // Asynchronous reset in the middle of COMPUTE
    drive(2'd1, 32'h600, 1'b0, 32'h0, 1'b0);
    tick();
    chk("pre-rst busy", 64'(sif.Busy), 64'd1);
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_vals("mid-rst");
    tick();
    Reset = 1'b0;
    drive(2'd0, 32'h0, 1'b1, 32'h2, 1'b0);
    tick();
    chk("post-rst best", 64'(sif.BestSAD), 64'hFFFF_FFFF);
    chk("post-rst cnt", 64'(sif.CandCount), 64'd0);

    // Frame opcode with no window loaded
    drive(2'd1, 32'h700, 1'b0, 32'h0, 1'b0);
    #1;
    chk("nowin stall", 64'(sif.StallSAD), 64'd0);
    tick();
    chk("nowin start", 64'(sif.SadStart), 64'd0);
    chk("nowin busy", 64'(sif.Busy), 64'd0);
    chk("nowin err", 64'(sif.ErrNoWin), 64'd1);
    drive(2'd2, 32'h704, 1'b0, 32'h0, 1'b1);
    tick();
    chk("nowin set>clr", 64'(sif.ErrNoWin), 64'd1);
    drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("nowin clr", 64'(sif.ErrNoWin), 64'd0);
    chk("nowin win", 64'(sif.WinValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
